// File: rtl/riego_pkg.sv
// Shared state encoding, TEMP width, fault codes and the raw-to-code quantizer.
// Package only: no latency and no flow control of its own.
package riego_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUANT = 2'd2,
    HOLD  = 2'd3
  } tstate_e;

  localparam int TEMP_W = 3;
  localparam logic [TEMP_W-1:0] TEMP_MAX = '1;
  localparam logic [7:0] RAW_OPEN  = 8'h00;
  localparam logic [7:0] RAW_SHORT = 8'hFF;

  // Clamp in 9 bits before narrowing so large readings saturate instead of wrapping.
  function automatic logic [TEMP_W-1:0] temp_code(input logic [7:0] raw,
                                                  input logic [7:0] base,
                                                  input int         step_log2);
    logic [8:0]        d;
    logic [8:0]        q;
    logic [TEMP_W-1:0] code;
    d    = {1'b0, raw} - {1'b0, base};
    q    = d >> step_log2;
    code = q[TEMP_W-1:0];
    if (q > 9'(TEMP_MAX)) code = TEMP_MAX;
    if (d[8]) code = '0;
    return code;
  endfunction

endpackage

// File: rtl/riego_debounce.sv
// One switch channel: 2-flop synchronizer plus a stable-sample counter, output resets to 1.
// Latency 2 + DEB_CYCLES edges from capture to output change; no backpressure.
module riego_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A single sample that agrees with the output restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == 4'(DEB_CYCLES)) begin
      deb <= ~deb;
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/riego_sensor_front.sv
// Debounced HUMEDAD/AGUA/BOMBA plus periodic 8-bit serial TEMP read; SENSOR_FAULT_EN adds open/short detection.
// Latency: debounce 2+DEB_CYCLES edges, TEMP/TVALID 10 edges after CONV entry every 10+SAMPLE_PERIOD edges; no backpressure.
module riego_sensor_front
  import riego_pkg::*;
#(
  parameter int DEB_CYCLES    = 3,
  parameter int SAMPLE_PERIOD = 10,
  parameter int T_BASE        = 16,
  parameter int T_STEP_LOG2   = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              HUM_RAW,
  input  logic              AGUA_RAW,
  input  logic              BOMBA_RAW,
  input  logic              TSDA,
  output logic              TCS_N,
  output logic              HUMEDAD,
  output logic              AGUA,
  output logic              BOMBA,
  output logic [TEMP_W-1:0] TEMP,
  output logic              TVALID,
  output logic              TFAULT
);

  localparam int HW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SAMPLE_PERIOD);

  tstate_e           state;
  tstate_e           state_nxt;
  logic [2:0]        bit_cnt;
  logic [HW-1:0]     hold_cnt;
  logic [7:0]        shreg;
  logic [TEMP_W-1:0] code;
  logic              raw_bad;

  riego_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hum (
    .clk(CLK), .rst_n(RST_N), .raw(HUM_RAW), .deb(HUMEDAD)
  );
  riego_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_agua (
    .clk(CLK), .rst_n(RST_N), .raw(AGUA_RAW), .deb(AGUA)
  );
  riego_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_bomba (
    .clk(CLK), .rst_n(RST_N), .raw(BOMBA_RAW), .deb(BOMBA)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = CONV;
      CONV:    if (bit_cnt == 3'd7) state_nxt = QUANT;
      QUANT:   state_nxt = HOLD;
      HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = CONV;
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt wraps to 0 on the 8th bit, so every read starts from a clean count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt  <= '0;
      hold_cnt <= '0;
      shreg    <= '0;
    end else begin
      if (state == CONV) begin
        shreg   <= {shreg[6:0], TSDA};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == HOLD) hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HW'(1);
    end
  end

  assign code = temp_code(shreg, 8'(T_BASE), T_STEP_LOG2);

  // Chip select is registered and stays low through the QUANT cycle so it rises at E9.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TCS_N  <= 1'b1;
      TVALID <= 1'b0;
      TEMP   <= '0;
    end else begin
      TCS_N  <= !((state_nxt == CONV) || (state_nxt == QUANT));
      TVALID <= (state == QUANT);
      if ((state == QUANT) && !raw_bad) TEMP <= code;
    end
  end

`ifdef SENSOR_FAULT_EN
  assign raw_bad = (shreg == RAW_OPEN) || (shreg == RAW_SHORT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              TFAULT <= 1'b0;
    else if (state == QUANT) TFAULT <= raw_bad;
  end
`else
  assign raw_bad = 1'b0;
  assign TFAULT  = 1'b0;
`endif

endmodule

// File: tb/tb_riego_sensor_front.sv
// Bench for riego_sensor_front: schedule/window model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_riego_sensor_front;

  localparam int DEB = 3;
  localparam int SP  = 10;
  localparam int TB  = 16;
  localparam int TSL = 2;
  localparam int P   = 10 + SP;
  localparam int NP  = 11;
  localparam int NR  = 12;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       HUM_RAW = 1'b1;
  logic       AGUA_RAW = 1'b1;
  logic       BOMBA_RAW = 1'b1;
  logic       TSDA = 1'b0;
  logic       TCS_N, HUMEDAD, AGUA, BOMBA, TVALID, TFAULT;
  logic [2:0] TEMP;

  riego_sensor_front #(
    .DEB_CYCLES(DEB), .SAMPLE_PERIOD(SP), .T_BASE(TB), .T_STEP_LOG2(TSL)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .HUM_RAW(HUM_RAW), .AGUA_RAW(AGUA_RAW),
    .BOMBA_RAW(BOMBA_RAW), .TSDA(TSDA), .TCS_N(TCS_N), .HUMEDAD(HUMEDAD),
    .AGUA(AGUA), .BOMBA(BOMBA), .TEMP(TEMP), .TVALID(TVALID), .TFAULT(TFAULT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Raw readings the sensor serves, one per read (index 9 is the aborted read).
  logic [7:0] rd_tbl [NR] = '{8'h00, 8'd16, 8'd27, 8'd40, 8'd50, 8'd10,
                              8'd28, 8'hFF, 8'd20, 8'd44, 8'd33, 8'd44};
`ifdef SENSOR_FAULT_EN
  logic [2:0] lit_temp  [NP] = '{3'd0, 3'd0, 3'd2, 3'd6, 3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd4, 3'd7};
  logic       lit_fault [NP] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
  logic [2:0] lit_temp  [NP] = '{3'd0, 3'd0, 3'd2, 3'd6, 3'd7, 3'd0, 3'd3, 3'd7, 3'd1, 3'd4, 3'd7};
  logic       lit_fault [NP] = '{default: 1'b0};
`endif

  // Model state: e counts edges since reset release, ph is the position within a read cycle.
  int          e = -1;
  int          ph = 0;
  int          rd = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          mon_cnt = 0;
  bit          rst_evt = 1'b0;
  bit          mon_done = 1'b0;
  bit          flip;
  logic [7:0]  cur_raw = 8'h00;
  logic        m_tcs = 1'b1;
  logic        m_tvalid = 1'b0;
  logic        m_fault = 1'b0;
  logic [2:0]  m_temp = 3'd0;
  logic [2:0]  m_deb = 3'b111;
  logic [15:0] hist [3] = '{default: 16'hFFFF};
  logic [2:0]  raws;

  assign raws = {BOMBA_RAW, AGUA_RAW, HUM_RAW};

  function automatic int exp_code(input int raw);
    int d;
    int q;
    d = raw - TB;
    if (d < 0) return 0;
    q = d / (1 << TSL);
    return (q > 7) ? 7 : q;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      e = -1; m_tcs = 1'b1; m_tvalid = 1'b0; m_temp = 3'd0; m_fault = 1'b0; m_deb = 3'b111;
      for (int c = 0; c < 3; c++) hist[c] = 16'hFFFF;
    end else begin
      e++;
      ph = e % P;
      // Output flips once the synchronized samples of the last DEB+1 edges all disagree with it.
      for (int c = 0; c < 3; c++) begin
        hist[c] = {hist[c][14:0], raws[2'(c)]};
        flip = 1'b1;
        for (int j = 2; j <= DEB + 2; j++)
          if (hist[c][4'(j)] == m_deb[2'(c)]) flip = 1'b0;
        if (flip) m_deb[2'(c)] = ~m_deb[2'(c)];
      end
      if (ph == 0) begin
        cur_raw = (rd < NR) ? rd_tbl[rd] : 8'd16;
        rd++;
      end
      m_tcs    = (ph > 8);
      m_tvalid = (ph == 9);
      if (ph == 9) begin
`ifdef SENSOR_FAULT_EN
        if (cur_raw == 8'h00 || cur_raw == 8'hFF) m_fault = 1'b1;
        else begin
          m_fault = 1'b0;
          m_temp  = 3'(exp_code(int'(cur_raw)));
        end
`else
        m_temp = 3'(exp_code(int'(cur_raw)));
`endif
      end
    end
  end

  // Compare every cycle, then act as the sensor: next bit presented after each edge.
  initial forever begin
    @(negedge CLK);
    chk("tcs_n",   32'(TCS_N),   32'(m_tcs));
    chk("tvalid",  32'(TVALID),  32'(m_tvalid));
    chk("temp",    32'(TEMP),    32'(m_temp));
    chk("tfault",  32'(TFAULT),  32'(m_fault));
    chk("humedad", 32'(HUMEDAD), 32'(m_deb[0]));
    chk("agua",    32'(AGUA),    32'(m_deb[1]));
    chk("bomba",   32'(BOMBA),   32'(m_deb[2]));
    if (e < 0)        TSDA = 1'b0;
    else if (ph <= 7) TSDA = cur_raw[3'(7 - ph)];
    else              TSDA = 1'($urandom_range(0, 1));
  end

  // Literal per-read expectations and pulse spacing.
  initial begin
    int last_cyc;
    int w;
    last_cyc = 0;
    for (int i = 0; i < NP; i++) begin
      w = 0;
      do begin
        @(negedge CLK);
        w++;
      end while (TVALID !== 1'b1 && w < 80);
      chk("pulse_seen", 32'(TVALID), 1);
      chk("pulse_temp", 32'(TEMP), 32'(lit_temp[i]));
      chk("pulse_fault", 32'(TFAULT), 32'(lit_fault[i]));
      if (rst_evt) begin
        chk("first_pulse_after_reset", 32'(cyc - rel_cyc), 10);
        rst_evt = 1'b0;
      end else begin
        chk("pulse_spacing", 32'(cyc - last_cyc), 20);
      end
      last_cyc = cyc;
      mon_cnt++;
    end
    mon_done = 1'b1;
  end

  initial begin
    int w;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_humedad", 32'(HUMEDAD), 1);
    chk("rst_agua",    32'(AGUA), 1);
    chk("rst_bomba",   32'(BOMBA), 1);
    chk("rst_temp",    32'(TEMP), 0);
    chk("rst_tvalid",  32'(TVALID), 0);
    chk("rst_tfault",  32'(TFAULT), 0);
    chk("rst_tcs_n",   32'(TCS_N), 1);
    #1 RST_N = 1'b1;
    rel_cyc = cyc;
    rst_evt = 1'b1;
    @(posedge CLK);
    #1 chk("e0_tcs_n", 32'(TCS_N), 0);

    repeat (2) @(negedge CLK);
    HUM_RAW = 1'b0;
    repeat (5) @(posedge CLK);
    #1 chk("hum_hold_4", 32'(HUMEDAD), 1);
    @(posedge CLK);
    #1 chk("hum_fall_5", 32'(HUMEDAD), 0);

    @(negedge CLK);
    AGUA_RAW = 1'b0;
    repeat (2) @(negedge CLK);
    AGUA_RAW = 1'b1;
    repeat (8) @(negedge CLK);
    chk("agua_glitch", 32'(AGUA), 1);

    BOMBA_RAW = 1'b0;
    repeat (4) @(negedge CLK);
    BOMBA_RAW = 1'b1;
    repeat (2) @(negedge CLK);
    chk("bomba_fall", 32'(BOMBA), 0);
    repeat (3) @(negedge CLK);
    chk("bomba_hold", 32'(BOMBA), 0);
    @(negedge CLK);
    chk("bomba_rise", 32'(BOMBA), 1);
    HUM_RAW = 1'b1;

    w = 0;
    while (mon_cnt < 9 && w < 400) begin
      @(negedge CLK);
      w++;
    end
    chk("reached_read9", 32'(mon_cnt >= 9), 1);
    w = 0;
    do begin
      @(posedge CLK);
      #1;
      w++;
    end while (!(e >= 0 && ph == 5) && w < 40);
    chk("abort_phase", 32'(ph), 5);
    #1 RST_N = 1'b0;
    #1;
    chk("abort_tcs_n",  32'(TCS_N), 1);
    chk("abort_temp",   32'(TEMP), 0);
    chk("abort_tvalid", 32'(TVALID), 0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    rel_cyc = cyc;
    rst_evt = 1'b1;

    w = 0;
    while (!mon_done && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("all_reads_done", 32'(mon_done), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riego_sensor_front.md
# riego_sensor_front

Sensor acquisition front end for the irrigation controller: synchronizes and debounces the raw humidity, water-level and pump-feedback switches, and reads an 8-bit serial temperature sensor and quantizes it to the 3-bit TEMP code. It drives the controller's HUMEDAD, AGUA, BOMBA and TEMP inputs, sitting between the field sensors and the controller top.

## Interface
Parameters:
- DEB_CYCLES, 3: consecutive stable samples required before a debounced output changes (1..15).
- SAMPLE_PERIOD, 10: CLK cycles from the end of one temperature read to the start of the next (≥1).
- T_BASE, 16: raw temperature mapped to code 0.
- T_STEP_LOG2, 2: log2 of raw counts per TEMP code step.

Ports:
- CLK  in  1  system clock (1 Hz in the field, any rate in sim)
- RST_N  in  1  asynchronous active-low reset
- HUM_RAW  in  1  raw humidity switch, asynchronous
- AGUA_RAW  in  1  raw water-level switch, asynchronous
- BOMBA_RAW  in  1  raw pump-feedback switch, asynchronous
- TSDA  in  1  serial temperature data, MSB first
- TCS_N  out  1  sensor chip select, active low
- HUMEDAD  out  1  debounced humidity
- AGUA  out  1  debounced water level
- BOMBA  out  1  debounced pump feedback
- TEMP  out  3  quantized temperature code
- TVALID  out  1  one-cycle pulse when TEMP is updated
- TFAULT  out  1  sensor fault flag (see Configuration)

## Operation
- Clock is CLK; reset is asynchronous and active-low on RST_N.
- Reset values: HUMEDAD=1, AGUA=1, BOMBA=1, TEMP=0, TVALID=0, TFAULT=0, TCS_N=1, FSM in IDLE, all counters 0, sync flops 1.
- Debounce, per channel: 2-flop synchronizer, then a 4-bit counter. The counter increments while the synchronized sample differs from the output and clears when it matches. When it reaches DEB_CYCLES, the output toggles and the counter clears. Any single matching sample restarts the count. Channels are independent.
- Temperature FSM:
  - IDLE → CONV on the first edge after reset release.
  - CONV: TCS_N=0; bit counter 0..7; shift TSDA into an 8-bit register on each edge; after the 8th bit → QUANT.
  - QUANT: TCS_N=1; compute the code; update TEMP; pulse TVALID; → HOLD.
  - HOLD: count SAMPLE_PERIOD cycles → CONV.
- Quantization: d = raw − T_BASE as a 9-bit signed value. If d<0, code=0. Otherwise q = d >> T_STEP_LOG2 and code = min(q,7). All saturation happens before truncation to 3 bits; no wrap-around.
- Reset mid-read: the partial shift register is discarded, TEMP keeps its reset value of 0, and the read restarts from IDLE.

## Timing
- Debounce latency: an input step held stable changes the output 2 (sync) + DEB_CYCLES edges after it is first captured.
- Edge E0 enters CONV, so TCS_N is low from E0. TSDA bits are sampled on edges E1..E8, MSB first. The sensor presents a new bit after each edge.
- E9: QUANT. TCS_N goes high. TEMP and TVALID are registered at E9 and visible after E9; TVALID is high for exactly one cycle.
- HOLD spans SAMPLE_PERIOD cycles, so the next CONV entry is at E9+1+SAMPLE_PERIOD. Read cycle length is 10+SAMPLE_PERIOD edges.
- TEMP is stable between TVALID pulses. Debounced outputs may change in any cycle, including the cycle TVALID pulses.

## Configuration
- Macro SENSOR_FAULT_EN.
- Defined: in QUANT, raw 8'h00 or 8'hFF is treated as open/short. TFAULT is set to 1, TEMP holds its previous value, and TVALID still pulses. The next valid read clears TFAULT and updates TEMP.
- Undefined: TFAULT is tied 0, and 8'h00/8'hFF quantize normally (to 0 and 7).

## Structure
- Shared package riego_pkg holds:
  - the FSM state encoding (IDLE, CONV, QUANT, HOLD), 2 bits
  - the TEMP code width of 3
  - the fault codes RAW_OPEN=8'h00 and RAW_SHORT=8'hFF
- Sub-module riego_debounce (sync + counter, parameter DEB_CYCLES, reset value 1), instantiated three times. The FSM and quantizer stay in the top.

## Test plan
- Reset then release with all raw inputs at 1 and TSDA=0 → HUMEDAD/AGUA/BOMBA stay 1; TCS_N low at E0; TEMP=0 with TVALID at E9.
- HUM_RAW 1→0 held, DEB_CYCLES=3 → HUMEDAD falls 5 edges after capture. A 2-cycle 0-glitch on AGUA_RAW → AGUA never changes.
- Serial raw values 8'd16, 8'd27, 8'd40, 8'd10 → TEMP 0, 2, 6 (clamped at 7 beyond 8'd44), 0; one TVALID per read, spaced 10+SAMPLE_PERIOD edges.
- With SENSOR_FAULT_EN: raw 8'd28 then 8'hFF → TEMP=3; then TFAULT=1 with TEMP held at 3. A following 8'd20 → TFAULT=0, TEMP=1. Without the macro, 8'hFF → TEMP=7, TFAULT=0.
- RST_N asserted at bit 4 of CONV → TCS_N=1 and TEMP=0 immediately (asynchronous); after release, a complete new read occurs and no TVALID is issued for the aborted read.
